proc_alu_lane_serializer: RTL

- Upstream neighbour of the processor datapath ALU wrapper stage.
- Accepts one packed subword-vector ALU request carrying a function code, a lane count and two 128-bit operand vectors.
- Issues that request to the ALU stage as a sequence of per-lane 70-bit messages, one lane per handshake, in ascending lane order.
- Lets the single-lane ALU stage execute 1–4-lane subword operations without modification.

---
 rtl/proc_alu_lane_pkg.sv | 28 ++
 rtl/proc_alu_lane_mux.sv | 23 ++
 rtl/proc_alu_lane_serializer.sv | 118 +++++++++++
 3 files changed

// File: rtl/proc_alu_lane_pkg.sv
// Shared constants, message field offsets and FSM encoding for the ALU lane serializer.
package proc_alu_lane_pkg;

  localparam int unsigned P_NLANES     = 4;
  localparam int unsigned P_LANE_NBITS = 32;
  localparam int unsigned P_FN_NBITS   = 6;
  localparam int unsigned P_CNT_NBITS  = 2;
  localparam int unsigned P_VEC_NBITS  = P_NLANES * P_LANE_NBITS;

  // Vector request: {fn, cnt, in0, in1}
  localparam int unsigned IMSG_NBITS   = P_FN_NBITS + P_CNT_NBITS + 2 * P_VEC_NBITS;
  localparam int unsigned IMSG_FN_LSB  = 258;
  localparam int unsigned IMSG_CNT_LSB = 256;
  localparam int unsigned IMSG_IN0_LSB = 128;
  localparam int unsigned IMSG_IN1_LSB = 0;

  // Lane message: {fn, in0_lane, in1_lane}
  localparam int unsigned OMSG_NBITS   = P_FN_NBITS + 2 * P_LANE_NBITS;
  localparam int unsigned OMSG_FN_LSB  = 64;
  localparam int unsigned OMSG_IN0_LSB = 32;
  localparam int unsigned OMSG_IN1_LSB = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/proc_alu_lane_mux.sv
// Combinational 4:1 selector picking one lane out of a packed operand vector.
module proc_alu_lane_mux
  import proc_alu_lane_pkg::*;
#(
  parameter int unsigned p_lane_nbits = P_LANE_NBITS
) (
  input  logic [4*p_lane_nbits-1:0] vec_i,
  input  logic [1:0]                sel_i,
  output logic [p_lane_nbits-1:0]   lane_o
);

  always_comb begin
    lane_o = '0;
    case (sel_i)
      2'd0:    lane_o = vec_i[0*p_lane_nbits +: p_lane_nbits];
      2'd1:    lane_o = vec_i[1*p_lane_nbits +: p_lane_nbits];
      2'd2:    lane_o = vec_i[2*p_lane_nbits +: p_lane_nbits];
      2'd3:    lane_o = vec_i[3*p_lane_nbits +: p_lane_nbits];
      default: lane_o = '0;
    endcase
  end

endmodule

// File: rtl/proc_alu_lane_serializer.sv
// Splits one packed subword-vector ALU request into per-lane messages issued
// in ascending lane order, one lane per handshake, with no bubble between requests.
module proc_alu_lane_serializer
  import proc_alu_lane_pkg::*;
#(
  parameter int unsigned p_nlanes     = P_NLANES,
  parameter int unsigned p_lane_nbits = P_LANE_NBITS,
  parameter int unsigned p_fn_nbits   = P_FN_NBITS
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                istream_val,
  output logic                                                istream_rdy,
  input  logic [p_fn_nbits+2+2*p_nlanes*p_lane_nbits-1:0]     istream_msg,
  output logic                                                ostream_val,
  input  logic                                                ostream_rdy,
  output logic [p_fn_nbits+2*p_lane_nbits-1:0]                ostream_msg,
  output logic                                                ostream_last
);

  localparam int unsigned LC_VEC  = p_nlanes * p_lane_nbits;
  localparam int unsigned LC_IMSG = p_fn_nbits + 2 + 2 * LC_VEC;
  localparam int unsigned LC_OMSG = p_fn_nbits + 2 * p_lane_nbits;

  state_e                  state_q, state_d;
  logic [1:0]              ctr_q, ctr_d;
  logic [p_fn_nbits-1:0]   fn_q;
  logic [1:0]              cnt_q;
  logic [LC_VEC-1:0]       in0_q, in1_q;
  logic [p_lane_nbits-1:0] in0_lane_s, in1_lane_s;
  logic                    last_s, load_s, ofire_s;

  proc_alu_lane_mux #(.p_lane_nbits(p_lane_nbits)) u_mux_in0 (
    .vec_i  (in0_q),
    .sel_i  (ctr_q),
    .lane_o (in0_lane_s)
  );

  proc_alu_lane_mux #(.p_lane_nbits(p_lane_nbits)) u_mux_in1 (
    .vec_i  (in1_q),
    .sel_i  (ctr_q),
    .lane_o (in1_lane_s)
  );

  // Handshake outputs are forced low while reset is held, even before the state settles.
  always_comb begin
    ostream_val  = 1'b0;
    last_s       = 1'b0;
    istream_rdy  = 1'b0;
    if (!reset) begin
      ostream_val = (state_q == ST_ISSUE);
      last_s      = (state_q == ST_ISSUE) && (ctr_q == cnt_q);
      istream_rdy = (state_q == ST_IDLE) || (last_s && ostream_rdy);
    end else begin
      ostream_val = 1'b0;
    end
    ostream_last = last_s & ostream_val;
    ostream_msg  = {fn_q, in0_lane_s, in1_lane_s} & {LC_OMSG{ostream_val}};
    load_s       = istream_val && istream_rdy;
    ofire_s      = ostream_val && ostream_rdy;
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_ISSUE;
          ctr_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ofire_s && !last_s) begin
          ctr_d = ctr_q + 2'd1;
        end else if (ofire_s && load_s) begin
          ctr_d = 2'd0;
        end else if (ofire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctr_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Request payload is captured only on an accepted istream transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q  <= '0;
      cnt_q <= 2'd0;
      in0_q <= '0;
      in1_q <= '0;
    end else if (load_s) begin
      fn_q  <= istream_msg[LC_IMSG-1 -: p_fn_nbits];
      cnt_q <= istream_msg[2*LC_VEC +: 2];
      in0_q <= istream_msg[LC_VEC +: LC_VEC];
      in1_q <= istream_msg[0 +: LC_VEC];
    end
  end

endmodule
